mem_program_loader: RTL and testbench
=====================================

Name: mem_program_loader

Overview:
- Sequencing controller in front of the program memory (mem_program).
- Normal run: passes the processor fetch address straight through to the memory, with write enable low.
- Load mode: stalls the processor and accepts a byte stream over a valid/ready handshake. It assembles the bytes MSB-first into INSTR_WIDTH-bit words and writes each word to consecutive addresses starting at a given base.
- Used for in-system reprogramming, with no re-synthesis.

Parameters:
- INSTR_WIDTH, 16, instruction word width; must be a multiple of 8.
- PC_WIDTH, 8, program address width; memory depth is 2^PC_WIDTH.
- BYTES_PER_WORD, INSTR_WIDTH/8, derived; not to be overridden.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  request a load; sampled only in IDLE.
- load_base  in  PC_WIDTH  first address to write; latched on accepted load_start.
- load_len  in  PC_WIDTH+1  number of words to write (0..2^PC_WIDTH); latched on accepted load_start.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  controller can accept a byte.
- fetch_pc  in  PC_WIDTH  processor fetch address.
- mem_we  out  1  to mem_program we.
- mem_addr  out  PC_WIDTH  to mem_program addr.
- mem_data  out  INSTR_WIDTH  to mem_program data_in.
- cpu_stall  out  1  holds the processor while a load is in progress.
- load_busy  out  1  high in any state other than IDLE.
- load_done  out  1  one-cycle completion pulse.
- words_loaded  out  PC_WIDTH+1  words written by the current or last load.

Behaviour:

States: IDLE, COLLECT, WRITE, DONE. Registered state; outputs decode from the state and registers only.

Reset (rst=1 at a clock edge):
- State becomes IDLE; byte counter, word counter, assembly register and words_loaded clear to 0.
- byte_ready=0, mem_we=0, cpu_stall=0, load_busy=0, load_done=0.
- mem_data=0; mem_addr=fetch_pc.

IDLE:
- mem_addr = fetch_pc (combinational passthrough); mem_we=0, byte_ready=0, cpu_stall=0.
- load_start=1 and load_len!=0:
  - Latch base and len; clear counters and words_loaded.
  - Go to COLLECT next cycle.
- load_start=1 and load_len==0:
  - Go to DONE with no memory write; words_loaded=0.

COLLECT:
- byte_ready=1, cpu_stall=1, mem_we=0, mem_addr=base+word_cnt.
- On a cycle with byte_valid & byte_ready:
  - assembly <= {assembly[INSTR_WIDTH-9:0], byte_in}; byte_cnt increments.
  - If this is byte BYTES_PER_WORD-1 of the word: byte_cnt <= 0 and go to WRITE.
- byte_valid low: hold all state; there is no timeout.

WRITE (exactly one cycle):
- mem_we=1, mem_addr = (base+word_cnt) mod 2^PC_WIDTH, mem_data=assembly.
- byte_ready=0, cpu_stall=1.
- Next edge: word_cnt and words_loaded increment.
- If word_cnt+1 == len, go to DONE; otherwise go to COLLECT.

DONE (one cycle):
- load_done=1, cpu_stall=1, byte_ready=0, mem_we=0.
- Next state is IDLE, where cpu_stall drops.

Timing and address rules:
- Minimum load duration from the load_start edge: len*(BYTES_PER_WORD+1)+1 cycles, with bytes back-to-back.
- Address wraps modulo 2^PC_WIDTH; there is no error on wrap.
- load_len = 2^PC_WIDTH fills the whole memory.

Boundary conditions:
- load_start outside IDLE: ignored; the latched base and len are unchanged.
- byte_valid in IDLE, WRITE or DONE: not accepted (byte_ready=0); the byte is not consumed.
- rst mid-load:
  - Returns to IDLE immediately and the partial word is discarded.
  - Words already written stay in memory.
  - words_loaded clears to 0.
- rst has priority over every other input.
- mem_data holds its last value outside WRITE; only mem_we qualifies it.

Test Plan:
1. Reset, then fetch_pc=0x12 in IDLE -> mem_addr=0x12; mem_we, cpu_stall, byte_ready and load_done all 0.
2. load_base=0x10, load_len=2; bytes 0xA5,0x5A,0x12,0x34 sent back-to-back -> write 0x10<=0xA55A then 0x11<=0x1234, each with a single mem_we cycle. load_done pulses 7 cycles after start; words_loaded=2; cpu_stall high throughout and low the next cycle. Bench memory model must match.
3. Same load as scenario 2 with byte_valid gapped 3 cycles between bytes -> no mem_we until the second byte of each word is accepted; data and addresses identical.
4. load_base=0xFF, load_len=2 -> writes to addresses 0xFF then 0x00.
5. load_len=0 -> load_done pulse one cycle after start, no mem_we. A second load_start pulsed while COLLECT is active -> ignored, original base and len kept.
6. rst asserted after the first byte of a word -> IDLE next cycle, no mem_we, cpu_stall=0, words_loaded=0, mem_addr=fetch_pc.

Source files
------------

// File: rtl/mem_program_loader.sv
// mem_program_loader: sequencing controller in front of mem_program.
// Normal run passes the fetch address through to the memory. Load mode
// stalls the processor, accepts a byte stream over valid/ready, assembles
// bytes MSB-first into instruction words and writes them to consecutive
// addresses starting at a latched base.
module mem_program_loader #(
  parameter int INSTR_WIDTH    = 16,
  parameter int PC_WIDTH       = 8,
  parameter int BYTES_PER_WORD = INSTR_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic [PC_WIDTH-1:0]    load_base,
  input  logic [PC_WIDTH:0]      load_len,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  input  logic [PC_WIDTH-1:0]    fetch_pc,
  output logic                   mem_we,
  output logic [PC_WIDTH-1:0]    mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_data,
  output logic                   cpu_stall,
  output logic                   load_busy,
  output logic                   load_done,
  output logic [PC_WIDTH:0]      words_loaded
);

  localparam int BCW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [PC_WIDTH-1:0]    base_q;
  logic [PC_WIDTH:0]      len_q;
  logic [PC_WIDTH:0]      word_cnt;
  logic [PC_WIDTH:0]      words_q;
  logic [BCW-1:0]         byte_cnt;
  logic [INSTR_WIDTH-1:0] assembly;
  logic [INSTR_WIDTH-1:0] asm_shift;
  logic [INSTR_WIDTH-1:0] data_q;
  logic                   accept;

  // State register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    cpu_stall  = 1'b1;
    load_busy  = 1'b1;
    load_done  = 1'b0;
    mem_addr   = base_q + word_cnt[PC_WIDTH-1:0];
    asm_shift  = (assembly << 8) | INSTR_WIDTH'(byte_in);
    case (state)
      IDLE: begin
        cpu_stall = 1'b0;
        load_busy = 1'b0;
        mem_addr  = fetch_pc;
        if (load_start) state_next = (load_len == '0) ? DONE : COLLECT;
      end
      COLLECT: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_cnt == LAST_BYTE) state_next = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (word_cnt + (PC_WIDTH+1)'(1) == len_q) state_next = DONE;
        else                                      state_next = COLLECT;
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    accept = byte_valid & byte_ready;
  end

  // Load datapath: latch request, assemble bytes, count written words.
  // The write word is captured in data_q as the final byte arrives so that
  // mem_data stays stable outside WRITE while the assembly register refills.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      len_q    <= '0;
      word_cnt <= '0;
      words_q  <= '0;
      byte_cnt <= '0;
      assembly <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            base_q   <= load_base;
            len_q    <= load_len;
            word_cnt <= '0;
            words_q  <= '0;
            byte_cnt <= '0;
            assembly <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            assembly <= asm_shift;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              data_q   <= asm_shift;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          word_cnt <= word_cnt + 1'b1;
          words_q  <= words_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_data     = data_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_mem_program_loader.sv
// Directed bench for mem_program_loader: hand-computed expected writes,
// addresses, timing and boundary behaviour.
module tb_mem_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [7:0]  load_base;
  logic [8:0]  load_len;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  fetch_pc;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic        cpu_stall;
  logic        load_busy;
  logic        load_done;
  logic [8:0]  words_loaded;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [15:0] mem_model [256];
  logic [7:0]  wr_addr [64];
  logic [15:0] wr_data [64];
  int          nwr = 0;
  logic [7:0]  stim [8];

  mem_program_loader #(.INSTR_WIDTH(16), .PC_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
    .load_len(load_len), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .fetch_pc(fetch_pc), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .cpu_stall(cpu_stall),
    .load_busy(load_busy), .load_done(load_done), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Program memory model plus a log of every write the controller issues.
  always @(posedge clk) begin
    if (mem_we) begin
      mem_model[mem_addr] <= mem_data;
      if (nwr < 64) begin
        wr_addr[nwr] <= mem_addr;
        wr_data[nwr] <= mem_data;
      end
      nwr <= nwr + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a load and stream stim[0..nbytes-1], idling 'gap' cycles after
  // each accepted byte. Returns the cycle (1 = cycle after the start edge)
  // in which load_done is seen, or -1 on timeout.
  task automatic run_load(input logic [7:0] base, input logic [8:0] len,
                          input int nbytes, input int gap,
                          output int done_cyc, output int stall_ok);
    int   idx;
    int   gap_cnt;
    int   cyc;
    logic acc;
    load_base  = base;
    load_len   = len;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    cyc      = 1;
    idx      = 0;
    gap_cnt  = 0;
    done_cyc = -1;
    stall_ok = 1;
    while (cyc < 3000) begin
      if (load_done) begin
        done_cyc = cyc;
        break;
      end
      if (cpu_stall !== 1'b1) stall_ok = 0;
      byte_valid = (idx < nbytes) && (gap_cnt == 0);
      byte_in    = byte_valid ? stim[idx] : 8'h00;
      acc        = byte_valid && byte_ready;
      step();
      if (acc) begin
        idx++;
        gap_cnt = gap;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
      cyc++;
    end
    byte_valid = 1'b0;
    if (cpu_stall !== 1'b1) stall_ok = 0;
  endtask

  initial begin
    int dc;
    int so;
    int n0;
    rst = 1'b1; load_start = 1'b0; load_base = '0; load_len = '0;
    byte_in = '0; byte_valid = 1'b0; fetch_pc = 8'h12;
    step();
    step();
    rst = 1'b0;
    step();

    // 1: reset / idle passthrough
    check_eq("rst_mem_addr",   mem_addr, 32'h12);
    check_eq("rst_mem_we",     mem_we, 0);
    check_eq("rst_cpu_stall",  cpu_stall, 0);
    check_eq("rst_byte_ready", byte_ready, 0);
    check_eq("rst_load_done",  load_done, 0);
    check_eq("rst_load_busy",  load_busy, 0);
    check_eq("rst_mem_data",   mem_data, 0);
    check_eq("rst_words",      words_loaded, 0);
    fetch_pc = 8'h34;
    #1;
    check_eq("idle_passthru",  mem_addr, 32'h34);

    // 2: back-to-back load of two words at 0x10
    stim[0] = 8'hA5; stim[1] = 8'h5A; stim[2] = 8'h12; stim[3] = 8'h34;
    n0 = nwr;
    run_load(8'h10, 9'd2, 4, 0, dc, so);
    check_eq("s2_done_cycle", dc, 7);
    check_eq("s2_stall_held", so, 1);
    check_eq("s2_words",      words_loaded, 2);
    check_eq("s2_nwrites",    nwr - n0, 2);
    check_eq("s2_addr0",      wr_addr[n0], 32'h10);
    check_eq("s2_data0",      wr_data[n0], 32'hA55A);
    check_eq("s2_addr1",      wr_addr[n0+1], 32'h11);
    check_eq("s2_data1",      wr_data[n0+1], 32'h1234);
    check_eq("s2_mem10",      mem_model[8'h10], 32'hA55A);
    check_eq("s2_mem11",      mem_model[8'h11], 32'h1234);
    step();
    check_eq("s2_stall_low",  cpu_stall, 0);
    check_eq("s2_done_low",   load_done, 0);
    check_eq("s2_idle_addr",  mem_addr, 32'h34);
    check_eq("s2_data_hold",  mem_data, 32'h1234);

    // 3: same load with gapped bytes
    mem_model[8'h10] = 16'h0; mem_model[8'h11] = 16'h0;
    n0 = nwr;
    run_load(8'h10, 9'd2, 4, 3, dc, so);
    check_eq("s3_done_seen",  dc > 7, 1);
    check_eq("s3_stall_held", so, 1);
    check_eq("s3_nwrites",    nwr - n0, 2);
    check_eq("s3_addr0",      wr_addr[n0], 32'h10);
    check_eq("s3_data0",      wr_data[n0], 32'hA55A);
    check_eq("s3_addr1",      wr_addr[n0+1], 32'h11);
    check_eq("s3_data1",      wr_data[n0+1], 32'h1234);
    check_eq("s3_mem11",      mem_model[8'h11], 32'h1234);
    step();

    // 4: address wrap from 0xFF to 0x00
    stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03; stim[3] = 8'h04;
    n0 = nwr;
    run_load(8'hFF, 9'd2, 4, 0, dc, so);
    check_eq("s4_done_cycle", dc, 7);
    check_eq("s4_nwrites",    nwr - n0, 2);
    check_eq("s4_addr0",      wr_addr[n0], 32'hFF);
    check_eq("s4_addr1",      wr_addr[n0+1], 32'h00);
    check_eq("s4_memFF",      mem_model[8'hFF], 32'h0102);
    check_eq("s4_mem00",      mem_model[8'h00], 32'h0304);
    step();

    // 5a: zero-length load
    n0 = nwr;
    run_load(8'h50, 9'd0, 0, 0, dc, so);
    check_eq("s5_done_cycle", dc, 1);
    check_eq("s5_nwrites",    nwr - n0, 0);
    check_eq("s5_words",      words_loaded, 0);
    step();
    check_eq("s5_idle",       load_busy, 0);

    // 5b: load_start while collecting is ignored
    n0 = nwr;
    load_base = 8'h20; load_len = 9'd1; load_start = 1'b1;
    step();
    load_base = 8'h40; load_len = 9'd5;
    step();
    load_start = 1'b0;
    check_eq("s5b_addr_kept", mem_addr, 32'h20);
    check_eq("s5b_busy",      load_busy, 1);
    byte_valid = 1'b1; byte_in = 8'hBE;
    step();
    byte_in = 8'hEF;
    step();
    byte_valid = 1'b0;
    check_eq("s5b_we",        mem_we, 1);
    check_eq("s5b_wr_addr",   mem_addr, 32'h20);
    check_eq("s5b_wr_data",   mem_data, 32'hBEEF);
    step();
    check_eq("s5b_done",      load_done, 1);
    check_eq("s5b_words",     words_loaded, 1);
    check_eq("s5b_nwrites",   nwr - n0, 1);
    step();

    // 6: reset after the first byte of a word
    fetch_pc = 8'h77;
    n0 = nwr;
    load_base = 8'h30; load_len = 9'd2; load_start = 1'b1;
    step();
    load_start = 1'b0;
    byte_valid = 1'b1; byte_in = 8'h11;
    step();
    byte_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("s6_busy",       load_busy, 0);
    check_eq("s6_stall",      cpu_stall, 0);
    check_eq("s6_words",      words_loaded, 0);
    check_eq("s6_we",         mem_we, 0);
    check_eq("s6_addr",       mem_addr, 32'h77);
    check_eq("s6_ready",      byte_ready, 0);
    check_eq("s6_nwrites",    nwr - n0, 0);
    check_eq("s6_mem_kept",   mem_model[8'h10], 32'hA55A);
    step();
    check_eq("s6_still_idle", load_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
